// File: rtl/bpsk_tx_scheduler.sv
// bpsk_tx_scheduler
//   Frames a byte stream for a BPSK modulator. Each frame is PRE_LEN copies of
//   PRE_BYTE followed by len payload bytes. Every bit is sent MSB first and is
//   held on mod_in for SPS clock cycles. A one-byte holding buffer in front of
//   the output shift register lets the next payload byte be fetched while the
//   current byte is still being sent.
//
// Parameters
//   SPS       samples (clock cycles) per bit, 2..255
//   PRE_BYTE  preamble byte pattern
//   PRE_LEN   number of preamble bytes, 1..15
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   start     single-cycle frame request, honoured only in IDLE with len != 0
//   len       payload byte count, sampled together with start
//   s_data    payload byte
//   s_valid   s_data is valid
//   s_ready   scheduler takes a byte this cycle
//   mod_en    modulator enable (same as busy)
//   mod_in    modulator bit (0 whenever mod_en is 0)
//   busy      frame in progress
//   done      one-cycle pulse when a frame completes normally
//   underrun  one-cycle pulse when a frame is aborted for lack of data
module bpsk_tx_scheduler #(
    parameter int         SPS      = 8,
    parameter logic [7:0] PRE_BYTE = 8'hAA,
    parameter int         PRE_LEN  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       mod_en,
    output logic       mod_in,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2
    } state_t;

    localparam logic [7:0] SPS_M1 = 8'(SPS - 1);
    localparam logic [3:0] PRE_M1 = 4'(PRE_LEN - 1);

    state_t     state;
    logic [7:0] samp;       // sample index within the current bit
    logic [2:0] bitc;       // bit index within the current byte
    logic [3:0] pre_cnt;    // preamble byte index
    logic [7:0] sh;         // output shift register, MSB goes out first
    logic [7:0] hold;       // holding buffer
    logic       hold_full;
    logic [7:0] acc;        // payload bytes accepted into the buffer
    logic [7:0] sent;       // payload bytes loaded into the shift register
    logic [7:0] len_q;
    logic       done_q;
    logic       undr_q;

    logic       samp_end;
    logic       byte_end;
    logic       xfer;

    assign busy     = (state != IDLE);
    assign mod_en   = busy;
    assign mod_in   = busy & sh[7];
    assign done     = done_q;
    assign underrun = undr_q;

    // acc counts accepted bytes, so the buffer never asks for more than len.
    assign s_ready  = busy & ~hold_full & (acc < len_q);
    assign xfer     = s_valid & s_ready;
    assign samp_end = (samp == SPS_M1);
    assign byte_end = samp_end & (bitc == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            samp      <= '0;
            bitc      <= '0;
            pre_cnt   <= '0;
            sh        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            acc       <= '0;
            sent      <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            undr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            undr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (len != 8'd0)) begin
                        state     <= PRE;
                        len_q     <= len;
                        acc       <= '0;
                        sent      <= '0;
                        hold_full <= 1'b0;
                        samp      <= '0;
                        bitc      <= '0;
                        pre_cnt   <= '0;
                        sh        <= PRE_BYTE;
                    end
                end
                PRE, PAY: begin
                    if (samp_end) begin
                        samp <= '0;
                        bitc <= bitc + 3'd1;
                        sh   <= {sh[6:0], 1'b0};
                    end else begin
                        samp <= samp + 8'd1;
                    end

                    if (byte_end) begin
                        if ((state == PRE) && (pre_cnt != PRE_M1)) begin
                            pre_cnt <= pre_cnt + 4'd1;
                            sh      <= PRE_BYTE;
                        end else if ((state == PAY) && (sent == len_q)) begin
                            // last payload byte just finished
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else if (hold_full) begin
                            state     <= PAY;
                            sh        <= hold;
                            hold_full <= 1'b0;
                            sent      <= sent + 8'd1;
                        end else begin
                            // a payload byte is due but none is buffered
                            undr_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end

                    // Placed after the load so a fill in the same cycle wins
                    // and the new byte ends up in the buffer.
                    if (xfer) begin
                        hold      <= s_data;
                        hold_full <= 1'b1;
                        acc       <= acc + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Scoreboard bench for bpsk_tx_scheduler (SPS=4, PRE_LEN=1, PRE_BYTE=AA).
// Stimulus pushes the expected mod_in samples and the expected end event of
// each frame into a queue; the monitor pops one entry per mod_en cycle and
// one per done/underrun pulse.
module tb_bpsk_tx_scheduler;

    localparam int         SPS      = 4;
    localparam int         PRE_LEN  = 1;
    localparam logic [7:0] PRE_BYTE = 8'hAA;

    localparam logic [1:0] K_BIT = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_UNDR = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic       bitv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready, mod_en, mod_in, busy, done, underrun;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    bpsk_tx_scheduler #(.SPS(SPS), .PRE_BYTE(PRE_BYTE), .PRE_LEN(PRE_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mod_en(mod_en), .mod_in(mod_in), .busy(busy),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mod_en) begin
            if (q.size() == 0) begin
                chk("unexpected_mod_en", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sample_kind", 32'(K_BIT), 32'(e.kind));
                chk("mod_in", 32'(mod_in), 32'(e.bitv));
            end
        end else begin
            chk("mod_in_idle", 32'(mod_in), 32'd0);
        end
        chk("busy_eq_mod_en", 32'(busy), 32'(mod_en));
        if (done && underrun) chk("done_and_underrun", 32'd1, 32'd0);
        if (done || underrun) begin
            if (q.size() == 0) begin
                chk("unexpected_end_event", {30'd0, underrun, done}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("end_event", {30'd0, underrun, done}, 32'(e.kind));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            for (int s = 0; s < SPS; s++) q.push_back('{K_BIT, b[i]});
    endtask

    // Expected stream: preamble, payload bytes p[0..n-1], then the end event.
    task automatic push_frame(input logic [7:0] p[], input int n, input logic [1:0] ev);
        for (int k = 0; k < PRE_LEN; k++) push_byte(PRE_BYTE);
        for (int k = 0; k < n; k++) push_byte(p[k]);
        q.push_back('{ev, 1'b0});
    endtask

    task automatic start_frame(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic feed_byte(input logic [7:0] b, input int dly);
        int   t;
        logic r;
        t = 0;
        while (!s_ready && t < 2000) begin
            step();
            t++;
        end
        if (t >= 2000) chk("s_ready_timeout", 32'd1, 32'd0);
        repeat (dly) step();
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        do begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 2000);
        if (!r) chk("xfer_timeout", 32'd1, 32'd0);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 3000) begin
            step();
            t++;
        end
        if (t >= 3000) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
        repeat (3) step();
        chk({name, "_queue_drained"}, 32'(q.size()), 32'd0);
        chk({name, "_s_ready_idle"}, 32'(s_ready), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [7:0] p[];
        int         c;

        #2;
        chk("rst_mod_en", 32'(mod_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_done_underrun", {30'd0, done, underrun}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single byte: AA then C3, 64 cycles, one done
        p = new[1];
        p[0] = 8'hC3;
        push_frame(p, 1, K_DONE);
        start_frame(8'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_first_bit", 32'(mod_in), 32'd1);
        feed_byte(8'hC3, 0);
        wait_idle("single");

        // back-pressure: valid two cycles after ready, no gaps
        p = new[3];
        p[0] = 8'h01; p[1] = 8'h02; p[2] = 8'h03;
        push_frame(p, 3, K_DONE);
        start_frame(8'd3);
        c = 1;
        feed_byte(8'h01, 2);
        feed_byte(8'h02, 2);
        feed_byte(8'h03, 2);
        wait_idle("backpressure");

        // underrun: len=2 but only one byte supplied
        p = new[1];
        p[0] = 8'h5A;
        push_frame(p, 1, K_UNDR);
        start_frame(8'd2);
        feed_byte(8'h5A, 0);
        wait_idle("underrun");

        // start with len=0 is ignored
        start_frame(8'd0);
        for (int i = 0; i < 3; i++) begin
            chk("len0_busy", 32'(busy), 32'd0);
            step();
        end

        // start during an active frame is ignored
        p = new[1];
        p[0] = 8'h81;
        push_frame(p, 1, K_DONE);
        start_frame(8'd1);
        feed_byte(8'h81, 0);
        repeat (20) step();
        start_frame(8'd5);
        wait_idle("busy_start");

        // mid-frame reset during payload
        p = new[2];
        p[0] = 8'hF0; p[1] = 8'h0F;
        push_frame(p, 2, K_DONE);
        start_frame(8'd2);
        feed_byte(8'hF0, 0);
        feed_byte(8'h0F, 0);
        repeat (10) step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {26'd0, s_ready, mod_en, mod_in, busy, done, underrun}, 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        // fresh frame right after release
        p = new[1];
        p[0] = 8'h3C;
        push_frame(p, 1, K_DONE);
        start_frame(8'd1);
        chk("fresh_busy", 32'(busy), 32'd1);
        feed_byte(8'h3C, 0);
        wait_idle("fresh");

        if (c != 1) chk("unused", 32'(c), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bpsk_tx_scheduler.md
BPSK_TX_SCHEDULER -- requirements
Module: bpsk_tx_scheduler

Interface
REQ-001 Parameter SPS, default 8: samples per symbol, i.e. clock cycles each bit is held on mod_in; legal range 2..255.
REQ-002 Parameter PRE_BYTE, default 8'hAA: preamble byte pattern.
REQ-003 Parameter PRE_LEN, default 2: preamble byte count; legal range 1..15.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle frame request.
REQ-008 len  in  8  payload byte count; sampled with start.
REQ-009 s_data  in  8  payload byte.
REQ-010 s_valid  in  1  s_data valid.
REQ-011 s_ready  out  1  scheduler accepts a byte this cycle.
REQ-012 mod_en  out  1  modulator enable.
REQ-013 mod_in  out  1  modulator bit.
REQ-014 busy  out  1  frame in progress.
REQ-015 done  out  1  one-cycle pulse on normal frame completion.
REQ-016 underrun  out  1  one-cycle pulse on frame abort.

Function
REQ-017 FSM states: IDLE, PRE, PAY.
REQ-018 IDLE -> PRE on start=1 with len!=0.
- len is latched on that edge.
- start with len=0 is ignored.
- start outside IDLE is ignored.
REQ-019 The first preamble bit appears on mod_in, with mod_en=1, in the cycle after the start edge.
REQ-020 Every bit, preamble and payload, is MSB first and held exactly SPS cycles.
- A sample counter 0..SPS-1 and a bit counter 0..7 wrap at a bit boundary and a byte boundary respectively.
REQ-021 PRE transmits PRE_BYTE PRE_LEN times, then moves directly to PAY at the byte boundary.
- No gap cycles.
REQ-022 A one-byte holding buffer sits in front of the output shift register.
- s_ready = busy AND buffer empty AND bytes_accepted < len_latched.
- A transfer occurs when s_valid=1 and s_ready=1.
- Accepting a byte during PRE (prefetch) is legal.
REQ-023 At each byte boundary entering or within PAY, the buffer content loads into the shift register and the buffer empties.
- A buffer fill and a shift load in the same cycle are both honoured: the newly accepted byte lands in the buffer after the load.
REQ-024 If the buffer is empty at a byte boundary that requires a payload byte, the frame aborts.
- underrun=1 for that cycle.
- Next state is IDLE; mod_en and busy drop the same cycle.
REQ-025 After the last sample of payload byte number len, the block pulses done=1 for one cycle, returns to IDLE, and drops mod_en and busy that same cycle.
REQ-026 busy=1 exactly while in PRE or PAY.
REQ-027 mod_en=busy.
REQ-028 mod_in=0 whenever mod_en=0.
REQ-029 done and underrun are never high together.
REQ-030 A new start is accepted in the cycle after done or underrun.
REQ-031 Total frame duration is (PRE_LEN+len)*8*SPS cycles of mod_en=1.

Reset
REQ-032 rst_n=0 forces the following immediately, asynchronously, including mid-frame:
- state IDLE; counters, buffer and latched len cleared.
- s_ready=0, mod_en=0, mod_in=0, busy=0, done=0, underrun=0.
REQ-033 After rst_n deasserts, the block accepts start on the first rising edge.

Verification
REQ-034 Single byte. SPS=4, PRE_LEN=1, PRE_BYTE=AA; start, len=1; s_data=8'hC3 held valid.
- Response: mod_in shows 1010_1010 then 1100_0011, each bit 4 cycles.
- mod_en high for 64 cycles; done pulses once; underrun never asserts.
REQ-035 Back-pressure. len=3, bytes 01/02/03; s_valid asserted only 2 cycles after each s_ready.
- Response: no gaps in mod_en, because the prefetch window suffices; done after 128 cycles (SPS=4, PRE_LEN=1).
REQ-036 Underrun. len=2; only the first byte is supplied.
- Response: underrun pulses at the byte-1 boundary; mod_en falls that cycle; done never pulses.
REQ-037 Ignored starts.
- start with len=0: busy stays 0.
- start during an active frame: frame length unchanged, no second done.
REQ-038 Mid-frame reset. rst_n=0 for 1 cycle during PAY.
- Response: all outputs 0 without a clock edge.
- A start one cycle after release begins a fresh preamble.
